uart_tx_sched: RTL

Transmit scheduler in front of `uart_tx`. It arbitrates up to `NUM_REQ` byte sources and two software flow-control characters (XOFF 0x13, XON 0x11) onto the single `uart_tx` valid/ready port. It sequences each frame through issue, completion and a programmable inter-frame idle gap. It sits between the TX FIFOs / protocol engines and `uart_tx`, and drives `uart_tx.i_valid` and `uart_tx.i_data`.

---
 rtl/uart_tx_sched_if.sv | 28 ++
 rtl/uart_tx_sched.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: byte-source and uart_tx handshake bundle for uart_tx_sched.
//   i_req_valid / i_req_data / o_req_ready : NUM_REQ byte requesters,
//                                            byte k on i_req_data[8k+7:8k]
//   o_tx_valid / i_tx_ready / o_tx_data     : valid/ready port into uart_tx
//   i_tx_done                               : frame-complete strobe from uart_tx
// Signal names are as seen from the scheduler; the slave modport is the
// scheduler, the master modport is its environment.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_req_valid;
    logic [NUM_REQ*8-1:0] i_req_data;
    logic [NUM_REQ-1:0]   o_req_ready;
    logic                 o_tx_valid;
    logic                 i_tx_ready;
    logic [7:0]           o_tx_data;
    logic                 i_tx_done;

    modport slave (
        input  i_req_valid, i_req_data, i_tx_ready, i_tx_done,
        output o_req_ready, o_tx_valid, o_tx_data
    );

    modport master (
        output i_req_valid, i_req_data, i_tx_ready, i_tx_done,
        input  o_req_ready, o_tx_valid, o_tx_data
    );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: arbitrates NUM_REQ byte sources plus XOFF (0x13) / XON (0x11)
// flow-control characters onto a single uart_tx valid/ready port, then waits
// for the frame to finish and inserts a programmable idle gap.
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_enable       : permits new grants (sampled in IDLE only)
//   bus            : requester and uart_tx handshake signals (slave modport)
//   i_xoff_send    : pulse, queue an XOFF
//   i_xon_send     : pulse, queue an XON
//   i_gap_cycles   : idle cycles inserted after each i_tx_done
//   o_busy         : registered, high whenever the FSM is not in IDLE
//   o_grant_id     : index of the last granted requester
//   o_ctrl_sent    : pulse on the uart_tx handshake of a control character
module uart_tx_sched #(
    parameter int NUM_REQ = 4,
    parameter int GAP_W   = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_enable,
    uart_tx_sched_if.slave             bus,
    input  logic                       i_xoff_send,
    input  logic                       i_xon_send,
    input  logic [GAP_W-1:0]           i_gap_cycles,
    output logic                       o_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic                       o_ctrl_sent
);
    localparam int          ID_W   = $clog2(NUM_REQ);
    localparam int unsigned NREQ_U = NUM_REQ;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t            state;
    logic              xoff_pend;
    logic              xon_pend;
    logic              is_ctrl;
    logic [GAP_W-1:0]  gap_cnt;
    logic [ID_W-1:0]   last;
    logic              tx_valid_q;
    logic [7:0]        tx_data_q;

    logic [7:0]        req_bytes [NUM_REQ];
    logic              rr_found;
    logic [ID_W-1:0]   rr_idx;
    logic [ID_W-1:0]   cand_idx;
    int unsigned       cand;
    logic              can_grant;
    logic              sel_xoff;
    logic              sel_xon;
    logic              sel_req;
    logic              xoff_nxt;
    logic              xon_nxt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = bus.i_req_data[8*g +: 8];
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 1; i <= NREQ_U; i++) begin
            cand = 32'(last) + i;
            if (cand >= NREQ_U) begin
                cand = cand - NREQ_U;
            end
            cand_idx = ID_W'(cand);
            if (!rr_found && bus.i_req_valid[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    // Reset gates the grant so o_req_ready reads zero while i_rst is held.
    assign can_grant = (state == S_IDLE) && i_enable && !i_rst;
    assign sel_xoff  = can_grant && xoff_pend;
    assign sel_xon   = can_grant && !xoff_pend && xon_pend;
    assign sel_req   = can_grant && !xoff_pend && !xon_pend && rr_found;

    always_comb begin
        bus.o_req_ready = '0;
        if (sel_req) begin
            bus.o_req_ready[rr_idx] = 1'b1;
        end
    end

    // A pulse for a flag that is already pending is absorbed: if that flag is
    // being captured this very cycle the result is cleared, not re-armed.
    always_comb begin
        xoff_nxt = xoff_pend && !sel_xoff;
        xon_nxt  = xon_pend && !sel_xon;
        if (i_xoff_send) begin
            xoff_nxt = !(xoff_pend && sel_xoff);
            xon_nxt  = 1'b0;
        end else if (i_xon_send) begin
            xon_nxt  = !(xon_pend && sel_xon);
            xoff_nxt = 1'b0;
        end
    end

    assign bus.o_tx_valid = tx_valid_q;
    assign bus.o_tx_data  = tx_data_q;
    assign o_ctrl_sent    = (state == S_ISSUE) && bus.i_tx_ready && is_ctrl;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            xoff_pend  <= 1'b0;
            xon_pend   <= 1'b0;
            is_ctrl    <= 1'b0;
            gap_cnt    <= '0;
            last       <= ID_W'(NUM_REQ - 1);
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            o_busy     <= 1'b0;
            o_grant_id <= '0;
        end else begin
            xoff_pend <= xoff_nxt;
            xon_pend  <= xon_nxt;
            unique case (state)
                S_IDLE: begin
                    if (sel_xoff || sel_xon || sel_req) begin
                        state      <= S_ISSUE;
                        o_busy     <= 1'b1;
                        tx_valid_q <= 1'b1;
                        is_ctrl    <= !sel_req;
                        if (sel_xoff) begin
                            tx_data_q <= 8'h13;
                        end else if (sel_xon) begin
                            tx_data_q <= 8'h11;
                        end else begin
                            tx_data_q  <= req_bytes[rr_idx];
                            last       <= rr_idx;
                            o_grant_id <= rr_idx;
                        end
                    end
                end
                S_ISSUE: begin
                    if (bus.i_tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state      <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.i_tx_done) begin
                        if (i_gap_cycles == '0) begin
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= i_gap_cycles;
                        end
                    end
                end
                S_GAP: begin
                    // Leaving on a count of 1 makes GAP last exactly i_gap_cycles.
                    if (gap_cnt == GAP_W'(1)) begin
                        state   <= S_IDLE;
                        o_busy  <= 1'b0;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
